crc_byte_sequencer: RTL and testbench

- Sequences a byte-serial CRC engine from a 32-bit word stream of known message length.
- Unpacks each accepted word into bytes, issues one trigger per byte, and tracks engine completion.
- Issues the final finalise pulse and raises a sticky completion interrupt.
- Sits between the TinyQV register interface (word FIFO/MMIO writes) and the crc32 engine; it replaces ad-hoc trigger logic in the peripheral wrapper.

---
 rtl/crc_byte_sequencer_if.sv | 19 +
 rtl/crc_byte_sequencer.sv | 159 +++++++++++++++
 tb/tb_crc_byte_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_byte_sequencer_if.sv
// Word stream handshake between the host FIFO/MMIO side and the sequencer.
// Ports: word_valid/word_data from master, word_ready from slave.
interface crc_byte_sequencer_if;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );
endinterface

// File: rtl/crc_byte_sequencer.sv
// Byte sequencer for a byte-serial CRC engine fed by a 32-bit word stream.
// Unpacks words into bytes, triggers the engine once per byte, finalises
// the result and raises a sticky completion irq.
// Ports: clk, rst_n (sync, active-low), start/msg_len/abort control,
//   word (word stream slave), crc_trigger/crc_byte/crc_busy/crc_done_pulse/
//   crc_finish engine side, busy/bytes_left/irq/irq_clr status.
// Optional: CRC_SEQ_WATCHDOG_EN adds an 8-bit stall watchdog and err output.
module crc_byte_sequencer #(
  parameter int LEN_W     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     msg_len,
  input  logic                 abort,
  crc_byte_sequencer_if.slave  word,
  output logic                 crc_trigger,
  output logic [7:0]           crc_byte,
  input  logic                 crc_busy,
  input  logic                 crc_done_pulse,
  output logic                 crc_finish,
  output logic                 busy,
  output logic [LEN_W-1:0]     bytes_left,
  output logic                 irq,
  input  logic                 irq_clr
`ifdef CRC_SEQ_WATCHDOG_EN
  ,
  output logic                 err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    ISSUE,
    WAIT_ENG,
    FINISH,
    DRAIN
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [31:0] word_q;
  logic [1:0]  lane;

`ifdef CRC_SEQ_WATCHDOG_EN
  logic [7:0]  wd_cnt;
`endif

  assign lane = LSB_FIRST ? byte_idx : (2'd3 - byte_idx);
  assign crc_byte = word_q[{lane, 3'b000} +: 8];

  // abort masks any handshake or pulse in the cycle it cancels
  assign word.word_ready = (state == WAIT_WORD) && !abort;
  assign crc_trigger = (state == ISSUE) && !crc_busy && !abort;
  assign crc_finish  = (state == FINISH) && !abort;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      word_q     <= 32'd0;
      bytes_left <= '0;
      irq        <= 1'b0;
`ifdef CRC_SEQ_WATCHDOG_EN
      wd_cnt     <= 8'd0;
      err        <= 1'b0;
`endif
    end else begin
      // clear first; a same-cycle set below overrides it
      if (irq_clr) begin
        irq <= 1'b0;
      end
`ifdef CRC_SEQ_WATCHDOG_EN
      if (irq_clr) begin
        err <= 1'b0;
      end
      wd_cnt <= 8'd0;
`endif
      if (abort && state != IDLE) begin
        state      <= IDLE;
        bytes_left <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (msg_len != '0) begin
                bytes_left <= msg_len;
                state      <= WAIT_WORD;
              end else begin
                state <= FINISH;
              end
            end
          end
          WAIT_WORD: begin
            if (word.word_valid) begin
              word_q   <= word.word_data;
              byte_idx <= 2'd0;
              state    <= ISSUE;
            end
          end
          ISSUE: begin
            if (!crc_busy) begin
              state <= WAIT_ENG;
            end
          end
          WAIT_ENG: begin
            if (crc_done_pulse) begin
              if (bytes_left <= LEN_W'(1)) begin
                bytes_left <= '0;
                state      <= FINISH;
              end else begin
                bytes_left <= bytes_left - LEN_W'(1);
                if (byte_idx == 2'd3) begin
                  state <= WAIT_WORD;
                end else begin
                  byte_idx <= byte_idx + 2'd1;
                  state    <= ISSUE;
                end
              end
            end
`ifdef CRC_SEQ_WATCHDOG_EN
            else if (wd_cnt == 8'd254) begin
              state      <= IDLE;
              bytes_left <= '0;
              err        <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 8'd1;
            end
`endif
          end
          FINISH: begin
            state <= DRAIN;
          end
          DRAIN: begin
            if (!crc_busy) begin
              irq   <= 1'b1;
              state <= IDLE;
            end
`ifdef CRC_SEQ_WATCHDOG_EN
            else if (wd_cnt == 8'd254) begin
              state <= IDLE;
              err   <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 8'd1;
            end
`endif
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc_byte_sequencer.sv
// Randomised bench for crc_byte_sequencer with a multi-cycle engine model
// and a queue-based expected byte stream per message.
module tb_crc_byte_sequencer;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic             abort = 1'b0;
  logic             irq_clr = 1'b0;
  logic             crc_trigger;
  logic [7:0]       crc_byte;
  logic             crc_busy;
  logic             crc_done_pulse = 1'b0;
  logic             crc_finish;
  logic             busy;
  logic [LEN_W-1:0] bytes_left;
  logic             irq;
`ifdef CRC_SEQ_WATCHDOG_EN
  logic             err;
`endif

  crc_byte_sequencer_if ifc();

  crc_byte_sequencer #(.LEN_W(LEN_W), .LSB_FIRST(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .msg_len        (msg_len),
    .abort          (abort),
    .word           (ifc),
    .crc_trigger    (crc_trigger),
    .crc_byte       (crc_byte),
    .crc_busy       (crc_busy),
    .crc_done_pulse (crc_done_pulse),
    .crc_finish     (crc_finish),
    .busy           (busy),
    .bytes_left     (bytes_left),
    .irq            (irq),
    .irq_clr        (irq_clr)
`ifdef CRC_SEQ_WATCHDOG_EN
    ,
    .err            (err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // engine model and monitors
  int   eng_cnt = 0;
  int   eng_lat = 3;
  bit   hold_busy = 1'b0;
  bit   eng_mute = 1'b0;
  int   trig_cnt = 0;
  int   fin_cnt = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  int   rdy_cnt = 0;
  logic [7:0] cap_q[$];

  assign crc_busy = (eng_cnt != 0) || hold_busy;

  always @(posedge clk) begin
    crc_done_pulse <= 1'b0;
    if (!rst_n) begin
      eng_cnt <= 0;
    end else if (crc_trigger) begin
      cap_q.push_back(crc_byte);
      trig_cnt <= trig_cnt + 1;
      eng_cnt  <= eng_lat;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_mute) crc_done_pulse <= 1'b1;
    end
    if (crc_done_pulse) done_cnt <= done_cnt + 1;
    if (crc_finish) fin_cnt <= fin_cnt + 1;
    if (ifc.word_valid && ifc.word_ready) xfer_cnt <= xfer_cnt + 1;
    if (ifc.word_ready) rdy_cnt <= rdy_cnt + 1;
  end

  // word source: presents words[rd_ptr..wr_ptr-1] with random gaps
  logic [31:0] words [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int skip_to = 0;
  int f_nxt;

  always_comb begin
    f_nxt = rd_ptr + ((ifc.word_valid && ifc.word_ready) ? 1 : 0);
    if (f_nxt < skip_to) f_nxt = skip_to;
  end

  always @(posedge clk) begin
    rd_ptr <= f_nxt;
    ifc.word_valid <= rst_n && (f_nxt < wr_ptr) && ($urandom_range(3) != 0);
    ifc.word_data  <= words[f_nxt[9:0]];
  end

  logic [31:0] preset_w [0:2] = '{32'h34333231, 32'h38373635, 32'h00000039};

  function automatic logic [31:0] crc32_of(input int from, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, cap_q[from+i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic load_words(input int len, input bit preset,
                            output logic [7:0] exp_q[$]);
    int nw;
    logic [31:0] tmp;
    nw = (len + 3) / 4;
    for (int i = 0; i < nw; i++)
      words[wr_ptr+i] = preset ? preset_w[i] : $urandom();
    exp_q = {};
    for (int k = 0; k < len; k++) begin
      tmp = words[wr_ptr + k/4] >> (8 * (k % 4));
      exp_q.push_back(tmp[7:0]);
    end
    wr_ptr = wr_ptr + nw;
  endtask

  task automatic run_msg(input int len, input int lat, input bit preset,
                         input bit race, input bit mid);
    int tb, fb, xb, cb, db, nw;
    bit fin;
    logic [7:0] exp_q[$];
    eng_lat = lat;
    nw = (len + 3) / 4;
    load_words(len, preset, exp_q);
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = race;
    chk("irq_cleared", 32'(irq), 0);
    tb = trig_cnt; fb = fin_cnt; xb = xfer_cnt;
    cb = cap_q.size(); db = done_cnt;
    start = 1'b1;
    msg_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    chk("bl_load", 32'(bytes_left), len);
    fin = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (mid && cyc == 4) begin
        start = 1'b1;
        msg_len = LEN_W'(len + 7);
      end
      @(negedge clk);
      start = 1'b0;
      if (mid && cyc == 4)
        chk("bl_midstart", 32'(bytes_left), len - (done_cnt - db));
      if (!busy) begin
        fin = 1'b1;
        if (race) begin
          chk("irq_race", 32'(irq), 1);
          irq_clr = 1'b0;
        end
      end
    end
    chk("msg_timeout", 32'(fin), 1);
    chk("triggers", trig_cnt - tb, len);
    chk("xfers", xfer_cnt - xb, nw);
    chk("finish", fin_cnt - fb, 1);
    chk("bl_end", 32'(bytes_left), 0);
    chk("irq_set", 32'(irq), 1);
    chk("cap_len", cap_q.size() - cb, len);
    for (int k = 0; k < len; k++)
      if (cb + k < cap_q.size())
        chk("byte", 32'(cap_q[cb+k]), 32'(exp_q[k]));
    if (preset && cap_q.size() - cb == len)
      chk("crc32", crc32_of(cb, len), 32'hCBF43926);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int tb, fb, xb, rb, db;
    bit seen;
    logic ir0;
    logic [7:0] exp_q[$];
    logic [31:0] w;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ifc.word_ready), 0);
    chk("rst_trig", 32'(crc_trigger), 0);
    chk("rst_byte", 32'(crc_byte), 0);
    chk("rst_fin", 32'(crc_finish), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bl", 32'(bytes_left), 0);
    chk("rst_irq", 32'(irq), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // nominal "123456789"
    run_msg(9, 3, 1'b1, 1'b0, 1'b0);

    // empty message
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    tb = trig_cnt; fb = fin_cnt; xb = xfer_cnt; rb = rdy_cnt;
    start = 1'b1;
    msg_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("empty_fin_hi", 32'(crc_finish), 1);
    @(negedge clk);
    chk("empty_fin_lo", 32'(crc_finish), 0);
    @(negedge clk);
    chk("empty_irq", 32'(irq), 1);
    chk("empty_busy", 32'(busy), 0);
    chk("empty_trig", trig_cnt - tb, 0);
    chk("empty_ready", rdy_cnt - rb, 0);
    chk("empty_xfer", xfer_cnt - xb, 0);
    chk("empty_fin_cnt", fin_cnt - fb, 1);

    // backpressure in ISSUE
    hold_busy = 1'b1;
    eng_lat = 2;
    load_words(4, 1'b0, exp_q);
    w = words[wr_ptr-1];
    tb = trig_cnt; xb = xfer_cnt;
    start = 1'b1;
    msg_len = LEN_W'(4);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (xfer_cnt - xb == 1) seen = 1'b1;
    end
    chk("bp_accept", 32'(seen), 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_trig", 32'(crc_trigger), 0);
      chk("bp_byte", 32'(crc_byte), 32'(w[7:0]));
      @(negedge clk);
    end
    chk("bp_none", trig_cnt - tb, 0);
    hold_busy = 1'b0;
    #1;
    chk("bp_release", 32'(crc_trigger), 1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    chk("bp_done", 32'(seen), 1);
    chk("bp_triggers", trig_cnt - tb, 4);

    // abort after the 2nd done pulse of a 6-byte message
    eng_lat = 3;
    load_words(6, 1'b0, exp_q);
    ir0 = irq;
    db = done_cnt; fb = fin_cnt;
    start = 1'b1;
    msg_len = LEN_W'(6);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt - db == 2) seen = 1'b1;
    end
    chk("abort_reach", 32'(seen), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_bl", 32'(bytes_left), 0);
    chk("abort_irq", 32'(irq), 32'(ir0));
    repeat (8) @(negedge clk);
    chk("abort_nofin", fin_cnt - fb, 0);
    skip_to = wr_ptr;
    @(negedge clk);
    run_msg(1, 2, 1'b0, 1'b0, 1'b0);

    // irq set/clear race plus ignored mid-message start
    run_msg(9, 3, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("irq_after_race", 32'(irq), 1);

    // randomised messages
    for (int m = 0; m < 8; m++)
      run_msg($urandom_range(23, 1), $urandom_range(4, 1), 1'b0, 1'b0, 1'b0);

    // reset mid-message
    eng_lat = 3;
    load_words(12, 1'b0, exp_q);
    start = 1'b1;
    msg_len = LEN_W'(12);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_bl", 32'(bytes_left), 0);
    chk("mrst_irq", 32'(irq), 0);
    chk("mrst_trig", 32'(crc_trigger), 0);
    chk("mrst_ready", 32'(ifc.word_ready), 0);
    chk("mrst_byte", 32'(crc_byte), 0);
    rst_n = 1'b1;
    skip_to = wr_ptr;
    @(negedge clk);
    run_msg(5, 1, 1'b0, 1'b0, 1'b0);

`ifdef CRC_SEQ_WATCHDOG_EN
    // engine never reports completion
    eng_mute = 1'b1;
    chk("wd_err_init", 32'(err), 0);
    load_words(2, 1'b0, exp_q);
    tb = trig_cnt; fb = fin_cnt;
    start = 1'b1;
    msg_len = LEN_W'(2);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (trig_cnt - tb == 1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("wd_trig", 32'(seen), 1);
    repeat (254) @(negedge clk);
    chk("wd_still_busy", 32'(busy), 1);
    @(negedge clk);
    chk("wd_idle", 32'(busy), 0);
    chk("wd_err", 32'(err), 1);
    chk("wd_nofin", fin_cnt - fb, 0);
    eng_mute = 1'b0;
    skip_to = wr_ptr;
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("wd_err_clr", 32'(err), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
